scm_tcdm_port_adapter: RTL and testbench
========================================

Name: scm_tcdm_port_adapter

Overview:
- Initiator side of a 1-read/1-write latch/flop register file.
- Accepts TCDM-style requests (req/gnt, byte enables) and drives the register file's ReadEnable/WriteEnable/WriteData port with registered outputs.
- Handles the file's 1-cycle read latency and performs read-modify-write for partial byte-enable writes.
- Returns one in-order response per granted request through a back-pressurable response FIFO.

Parameters:
- DATA_WIDTH, 64: data width; must be a multiple of 8.
- ADDR_WIDTH, 1: row address width (rf_addr_o, add_i).
- FIFO_DEPTH, 2: response FIFO entries and maximum outstanding requests (≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle (combinational from state/credits/req_i)
- we_i  in  1  1 = write, 0 = read
- add_i  in  ADDR_WIDTH  row address
- be_i  in  DATA_WIDTH/8  byte enables (writes only)
- wdata_i  in  DATA_WIDTH  write data
- r_valid_o  out  1  response valid (FIFO head)
- r_ready_i  in  1  response consumer ready
- r_rdata_o  out  DATA_WIDTH  read data; 0 for write responses
- rf_ReadEnable_o  out  1  register file read enable (registered)
- rf_WriteEnable_o  out  1  register file write enable (registered)
- rf_addr_o  out  ADDR_WIDTH  register file row address (registered)
- rf_WriteData_o  out  DATA_WIDTH  register file write data (registered)
- rf_ReadData_i  in  DATA_WIDTH  register file read data, valid the cycle after rf_ReadEnable_o

Behaviour:
- Reset (async, rst_n=0):
  - All rf_* outputs, r_valid_o, r_rdata_o, FIFO pointers/count, in-flight flags and credit counter go to 0.
  - FSM goes to IDLE.
  - Reset mid-operation drops all in-flight and queued responses; no rf write is issued after reset.
- Credits:
  - outstanding = FIFO count + operations granted but not yet pushed.
  - gnt_o = req_i & (state==IDLE) & (outstanding < FIFO_DEPTH).
  - A pop in the same cycle does not free a credit until the next cycle.
- Read granted in cycle T:
  - rf_ReadEnable_o=1, rf_addr_o=add_i in T+1.
  - rf_ReadData_i sampled and pushed in T+2.
  - r_valid_o=1 from T+3 if the FIFO was empty.
  - Back-to-back reads are granted every cycle while credits allow.
- Full write (be_i all ones) granted in T:
  - rf_WriteEnable_o=1, rf_WriteData_o=wdata_i in T+1.
  - Response (rdata 0) pushed in T+1; r_valid_o from T+2.
  - May be pipelined with reads.
- Zero write (be_i all zeros):
  - No rf access.
  - Response pushed in T+1; r_valid_o from T+2.
- Partial write (be_i mixed) granted in T; FSM path IDLE→RMW_RD→RMW_MERGE→RMW_WR→IDLE:
  - RMW_RD (T+1): rf_ReadEnable_o=1.
  - RMW_MERGE (T+2): merged = per-byte be ? wdata : rf_ReadData_i, registered.
  - RMW_WR (T+3): rf_WriteEnable_o=1 with merged data; response pushed.
  - IDLE from T+4: gnt_o=0 from T+1 through T+3.
  - r_valid_o from T+4 if the FIFO was empty.
- Ordering and hazards:
  - Responses are strictly in grant order.
  - The register file port is used in grant order, so a write in cycle N is visible to a read issued in N+1 or later; no forwarding is needed.
  - A partial write must not be granted while any earlier operation is still at the rf port in the same cycle.
  - gnt_o stays low unless IDLE, which gives this by construction.
- rf_ReadEnable_o and rf_WriteEnable_o are never both 1 in the same cycle.
  - A read and a full write granted in consecutive cycles occupy separate cycles.
  - The adapter grants at most one request per cycle.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop = r_valid_o & r_ready_i.
  - Overflow is impossible by credit accounting; an assertion checks count ≤ FIFO_DEPTH.
- No request is ever dropped: a request held with req_i=1 and gnt_o=0 waits.

Test Plan:
- Reset, then write add=0, be=all ones, wdata=0x1122334455667788, then read add=0 → rf_WriteEnable_o at T+1; read response r_rdata_o=0x1122334455667788 in T+3 after read grant.
- Partial write be=0x0F, wdata=0xAAAAAAAABBBBBBBB over stored 0x1122334455667788 → gnt_o low 3 cycles; rf_ReadEnable_o at T+1, rf_WriteEnable_o at T+3 with 0x11223344BBBBBBBB; later read returns that value.
- r_ready_i=0 with 4 back-to-back read requests, FIFO_DEPTH=2 → exactly 2 grants; gnt_o then low. After r_ready_i=1, the remaining 2 are granted, and all 4 responses arrive in order with correct data.
- Zero-byte-enable write → no rf_WriteEnable_o pulse; response r_rdata_o=0 at T+2; stored data unchanged.
- Interleaved read/full-write/read to the same row every cycle → enables never overlap; second read returns the newly written value.
- Assert rst_n low during RMW_MERGE → rf_WriteEnable_o never pulses; r_valid_o=0; the row keeps its old value; the next request is granted normally.

Source files
------------

// File: rtl/scm_tcdm_port_adapter.sv
// Purpose: TCDM req/gnt initiator for a 1R/1W latch/flop register file, with read-modify-write for partial byte enables.
// Latency: read data returns 3 cycles after grant, full/zero writes 2 cycles, partial writes 4 cycles (head of an empty FIFO).
// Backpressure: r_ready_i stalls the response FIFO; grants stop once queued plus in-flight responses reach FIFO_DEPTH.
module scm_tcdm_port_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    rf_ReadEnable_o,
  output logic                    rf_WriteEnable_o,
  output logic [ADDR_WIDTH-1:0]   rf_addr_o,
  output logic [DATA_WIDTH-1:0]   rf_WriteData_o,
  input  logic [DATA_WIDTH-1:0]   rf_ReadData_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_RD    = 2'd1,
    RMW_MERGE = 2'd2,
    RMW_WR    = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Register-file port next values
  logic                  re_nxt, we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  // Pipeline bookkeeping: rd_s1/rd_s2 track a plain read through the rf
  // latency, wr_s1 marks a full/zero write whose response is pushed next cycle.
  logic rd_s1, rd_s2, wr_s1;
  logic rd_s1_nxt, wr_s1_nxt;

  // Partial-write operands held across the RMW sequence
  logic                  rmw_cap;
  logic [BE_W-1:0]       rmw_be;
  logic [DATA_WIDTH-1:0] rmw_wdata;
  logic [DATA_WIDTH-1:0] merged;

  // Response FIFO and credit accounting
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr, rptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      out_cnt;
  logic                  push_rd, push_wr, pop;
  logic                  be_full, be_zero;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign be_full = &be_i;
  assign be_zero = ~|be_i;

  // out_cnt counts every granted request not yet popped, so it equals
  // FIFO occupancy plus operations still in flight toward a push.
  assign gnt_o = req_i && (state == IDLE) && (out_cnt < CNT_W'(FIFO_DEPTH));

  // A read granted two cycles ago is always older than a write granted one
  // cycle ago, so when both push together the read data goes in first.
  assign push_rd = rd_s2;
  assign push_wr = wr_s1 || (state == RMW_WR);
  assign pop     = r_valid_o && r_ready_i;

  assign r_valid_o = (fifo_cnt != '0);
  assign r_rdata_o = fifo_mem[rptr];

  // Byte merge of the held write data over the row read during RMW_RD
  always_comb begin
    merged = rf_ReadData_i;
    for (int b = 0; b < BE_W; b++) begin
      if (rmw_be[b]) begin
        merged[8*b +: 8] = rmw_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and rf port decode; grants only happen in IDLE, which keeps
  // the rf port in grant order and prevents read/write enable overlap.
  always_comb begin
    state_nxt = state;
    re_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = rf_addr_o;
    wdata_nxt = rf_WriteData_o;
    rd_s1_nxt = 1'b0;
    wr_s1_nxt = 1'b0;
    rmw_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_o) begin
          addr_nxt = add_i;
          if (!we_i) begin
            re_nxt    = 1'b1;
            rd_s1_nxt = 1'b1;
          end else if (be_full) begin
            we_nxt    = 1'b1;
            wdata_nxt = wdata_i;
            wr_s1_nxt = 1'b1;
          end else if (be_zero) begin
            wr_s1_nxt = 1'b1;
          end else begin
            re_nxt    = 1'b1;
            rmw_cap   = 1'b1;
            state_nxt = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        state_nxt = RMW_MERGE;
      end
      RMW_MERGE: begin
        we_nxt    = 1'b1;
        wdata_nxt = merged;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered register-file port and pipeline flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ReadEnable_o  <= 1'b0;
      rf_WriteEnable_o <= 1'b0;
      rf_addr_o        <= '0;
      rf_WriteData_o   <= '0;
      rd_s1            <= 1'b0;
      rd_s2            <= 1'b0;
      wr_s1            <= 1'b0;
    end else begin
      rf_ReadEnable_o  <= re_nxt;
      rf_WriteEnable_o <= we_nxt;
      rf_addr_o        <= addr_nxt;
      rf_WriteData_o   <= wdata_nxt;
      rd_s1            <= rd_s1_nxt;
      rd_s2            <= rd_s1;
      wr_s1            <= wr_s1_nxt;
    end
  end

  // Capture partial-write operands at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw_be    <= '0;
      rmw_wdata <= '0;
    end else if (rmw_cap) begin
      rmw_be    <= be_i;
      rmw_wdata <= wdata_i;
    end
  end

  // Response FIFO storage and pointers; up to two pushes and one pop per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_rd && push_wr) begin
        fifo_mem[wptr]          <= rf_ReadData_i;
        fifo_mem[ptr_inc(wptr)] <= '0;
        wptr                    <= ptr_inc(ptr_inc(wptr));
      end else if (push_rd || push_wr) begin
        fifo_mem[wptr] <= push_rd ? rf_ReadData_i : '0;
        wptr           <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push_rd) + CNT_W'(push_wr) - CNT_W'(pop);
    end
  end

  // Credit counter: a pop frees its credit only from the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CNT_W'(gnt_o) - CNT_W'(pop);
    end
  end

  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_cnt <= CNT_W'(FIFO_DEPTH));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    out_cnt <= CNT_W'(FIFO_DEPTH));

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(rf_ReadEnable_o && rf_WriteEnable_o));

endmodule

// File: tb/tb_scm_tcdm_port_adapter.sv
// Directed bench for scm_tcdm_port_adapter with a behavioural 2-row register file.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
// Expected values are hand-derived constants from the stimulus sequence.
module tb_scm_tcdm_port_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic        we;
  logic [0:0]  add;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_rdata;
  logic        rf_re;
  logic        rf_we;
  logic [0:0]  rf_addr;
  logic [63:0] rf_wdata;
  logic [63:0] rf_rdata;

  logic [63:0] rf_mem [2];

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ROW0_A = 64'h1122334455667788;
  localparam logic [63:0] ROW0_B = 64'h11223344BBBBBBBB;
  localparam logic [63:0] ROW1_A = 64'hCAFEF00D12345678;
  localparam logic [63:0] ROW1_B = 64'h0123456789ABCDEF;

  always #5 clk = ~clk;

  scm_tcdm_port_adapter #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(1),
    .FIFO_DEPTH(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (req),
    .gnt_o            (gnt),
    .we_i             (we),
    .add_i            (add),
    .be_i             (be),
    .wdata_i          (wdata),
    .r_valid_o        (r_valid),
    .r_ready_i        (r_ready),
    .r_rdata_o        (r_rdata),
    .rf_ReadEnable_o  (rf_re),
    .rf_WriteEnable_o (rf_we),
    .rf_addr_o        (rf_addr),
    .rf_WriteData_o   (rf_wdata),
    .rf_ReadData_i    (rf_rdata)
  );

  // Register file model: write lands at the edge, read data valid the cycle after ReadEnable
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    if (rf_re) rf_rdata <= rf_mem[rf_addr];
  end

  task automatic drive(input logic r, input logic w, input logic a,
                       input logic [7:0] b, input logic [63:0] d);
    req   = r;
    we    = w;
    add   = a;
    be    = b;
    wdata = d;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    r_ready = 1'b1;
    drive(0, 0, 0, 8'h00, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    #3;
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b exp 0", rf_re); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", rf_we); end
    checks++; if (rf_addr !== 1'b0) begin errors++; $display("FAIL reset_addr: got %h exp 0", rf_addr); end
    checks++; if (rf_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", rf_wdata); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", r_valid); end
    checks++; if (r_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", r_rdata); end
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b exp 0", gnt); end
    cyc;
    rst_n = 1'b1;
    cyc;
  endtask

  task automatic test_full_write_read;
    drive(1, 1, 0, 8'hFF, ROW0_A); #3;                                   // T
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL fw_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0); #3;                               // T+1
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL fw_we: got %b exp 1", rf_we); end
    checks++; if (rf_wdata !== ROW0_A) begin errors++; $display("FAIL fw_wdata: got %h exp %h", rf_wdata, ROW0_A); end
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL fw_re: got %b exp 0", rf_re); end
    cyc; #3;                                                              // T+2
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL fw_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== 64'h0) begin errors++; $display("FAIL fw_rdata: got %h exp 0", r_rdata); end
    cyc; drive(1, 0, 0, 8'h00, 64'h0); #3;                               // R
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b exp 1", gnt); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_rvalid: got %b exp 0", r_valid); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0); #3;                               // R+1
    checks++; if (rf_re !== 1'b1) begin errors++; $display("FAIL rd_re: got %b exp 1", rf_re); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b exp 0", rf_we); end
    cyc; #3;                                                              // R+2
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b exp 0", r_valid); end
    cyc; #3;                                                              // R+3
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== ROW0_A) begin errors++; $display("FAIL rd_rdata: got %h exp %h", r_rdata, ROW0_A); end
    cyc;
  endtask

  task automatic test_partial_write;
    drive(1, 1, 0, 8'h0F, 64'hAAAAAAAABBBBBBBB); #3;                   // P
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL pw_gnt: got %b exp 1", gnt); end
    cyc; drive(1, 0, 0, 8'h00, 64'h0); #3;                               // P+1, read held
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL pw_gnt_p1: got %b exp 0", gnt); end
    checks++; if (rf_re !== 1'b1) begin errors++; $display("FAIL pw_re_p1: got %b exp 1", rf_re); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pw_we_p1: got %b exp 0", rf_we); end
    cyc; #3;                                                              // P+2
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL pw_gnt_p2: got %b exp 0", gnt); end
    checks++; if ((rf_re | rf_we) !== 1'b0) begin errors++; $display("FAIL pw_idle_p2: got re=%b we=%b exp 0", rf_re, rf_we); end
    cyc; #3;                                                              // P+3
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL pw_gnt_p3: got %b exp 0", gnt); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pw_we_p3: got %b exp 1", rf_we); end
    checks++; if (rf_wdata !== ROW0_B) begin errors++; $display("FAIL pw_merge: got %h exp %h", rf_wdata, ROW0_B); end
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL pw_re_p3: got %b exp 0", rf_re); end
    cyc; #3;                                                              // P+4, read granted
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL pw_gnt_p4: got %b exp 1", gnt); end
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL pw_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== 64'h0) begin errors++; $display("FAIL pw_rdata: got %h exp 0", r_rdata); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0); #3;                               // P+5
    checks++; if (rf_re !== 1'b1) begin errors++; $display("FAIL pw_rd_re: got %b exp 1", rf_re); end
    cyc; cyc; #3;                                                         // P+7
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL pw_rd_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== ROW0_B) begin errors++; $display("FAIL pw_rd_rdata: got %h exp %h", r_rdata, ROW0_B); end
    cyc;
  endtask

  task automatic test_backpressure;
    logic [0:0]  addrs [4];
    logic [63:0] exp_d [4];
    int gi;
    int ri;
    addrs[0] = 1'b0; addrs[1] = 1'b1; addrs[2] = 1'b0; addrs[3] = 1'b1;
    exp_d[0] = ROW0_B; exp_d[1] = ROW1_A; exp_d[2] = ROW0_B; exp_d[3] = ROW1_A;
    drive(1, 1, 1, 8'hFF, ROW1_A); #3;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL bp_setup_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0);
    cyc; cyc;
    gi = 0;
    ri = 0;
    r_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 8) r_ready = 1'b1;
      if (gi < 4) drive(1, 0, addrs[gi], 8'h00, 64'h0);
      else drive(0, 0, 0, 8'h00, 64'h0);
      #3;
      if (c == 7) begin
        checks++; if (gi !== 2) begin errors++; $display("FAIL bp_stall_grants: got %0d exp 2", gi); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL bp_stall_gnt: got %b exp 0", gnt); end
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_rvalid: got %b exp 1", r_valid); end
        checks++; if (r_rdata !== ROW0_B) begin errors++; $display("FAIL bp_stall_head: got %h exp %h", r_rdata, ROW0_B); end
      end
      if (gnt && (gi < 4)) gi++;
      if (r_valid && r_ready && (ri < 4)) begin
        checks++; if (r_rdata !== exp_d[ri]) begin errors++; $display("FAIL bp_resp%0d: got %h exp %h", ri, r_rdata, exp_d[ri]); end
        ri++;
      end
      cyc;
    end
    checks++; if (gi !== 4) begin errors++; $display("FAIL bp_total_grants: got %0d exp 4", gi); end
    checks++; if (ri !== 4) begin errors++; $display("FAIL bp_total_resps: got %0d exp 4", ri); end
  endtask

  task automatic test_zero_write;
    drive(1, 1, 1, 8'h00, 64'hFFFFFFFFFFFFFFFF); #3;                   // Z
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL zw_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0); #3;                               // Z+1
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zw_we: got %b exp 0", rf_we); end
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL zw_re: got %b exp 0", rf_re); end
    cyc; #3;                                                              // Z+2
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zw_we2: got %b exp 0", rf_we); end
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL zw_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== 64'h0) begin errors++; $display("FAIL zw_rdata: got %h exp 0", r_rdata); end
    cyc; drive(1, 0, 1, 8'h00, 64'h0); #3;                               // Z+3
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL zw_rd_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0);
    cyc; cyc; #3;                                                         // Z+6
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL zw_rd_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== ROW1_A) begin errors++; $display("FAIL zw_rd_rdata: got %h exp %h", r_rdata, ROW1_A); end
    cyc;
  endtask

  task automatic test_back_to_back;
    logic        op_we [3];
    logic [63:0] op_d  [3];
    logic [63:0] exp_d [3];
    int oi;
    int ri;
    op_we[0] = 1'b0; op_d[0] = 64'h0;
    op_we[1] = 1'b1; op_d[1] = ROW1_B;
    op_we[2] = 1'b0; op_d[2] = 64'h0;
    exp_d[0] = ROW1_A; exp_d[1] = 64'h0; exp_d[2] = ROW1_B;
    oi = 0;
    ri = 0;
    for (int c = 0; c < 20; c++) begin
      if (oi < 3) drive(1, op_we[oi], 1'b1, 8'hFF, op_d[oi]);
      else drive(0, 0, 0, 8'h00, 64'h0);
      #3;
      checks++; if ((rf_re & rf_we) !== 1'b0) begin errors++; $display("FAIL b2b_overlap_c%0d: got re=%b we=%b exp not both", c, rf_re, rf_we); end
      if (gnt && (oi < 3)) oi++;
      if (r_valid && r_ready && (ri < 3)) begin
        checks++; if (r_rdata !== exp_d[ri]) begin errors++; $display("FAIL b2b_resp%0d: got %h exp %h", ri, r_rdata, exp_d[ri]); end
        ri++;
      end
      cyc;
    end
    checks++; if (oi !== 3) begin errors++; $display("FAIL b2b_grants: got %0d exp 3", oi); end
    checks++; if (ri !== 3) begin errors++; $display("FAIL b2b_resps: got %0d exp 3", ri); end
  endtask

  task automatic test_reset_mid_rmw;
    drive(1, 1, 0, 8'hF0, 64'h0); #3;                                    // P
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rr_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0); #3;                               // P+1 RMW_RD
    checks++; if (rf_re !== 1'b1) begin errors++; $display("FAIL rr_re: got %b exp 1", rf_re); end
    cyc; rst_n = 1'b0; #3;                                                // P+2 RMW_MERGE
    for (int c = 0; c < 3; c++) begin
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_we_rst%0d: got %b exp 0", c, rf_we); end
      checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rr_rvalid_rst%0d: got %b exp 0", c, r_valid); end
      cyc; #3;
    end
    cyc; rst_n = 1'b1; #3;
    for (int c = 0; c < 3; c++) begin
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_we_post%0d: got %b exp 0", c, rf_we); end
      checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rr_rvalid_post%0d: got %b exp 0", c, r_valid); end
      cyc; #3;
    end
    cyc; drive(1, 0, 0, 8'h00, 64'h0); #3;                               // R
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rr_rd_gnt: got %b exp 1", gnt); end
    cyc; drive(0, 0, 0, 8'h00, 64'h0);
    cyc; cyc; #3;                                                         // R+3
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL rr_rd_rvalid: got %b exp 1", r_valid); end
    checks++; if (r_rdata !== ROW0_B) begin errors++; $display("FAIL rr_rd_rdata: got %h exp %h", r_rdata, ROW0_B); end
    cyc;
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_backpressure();
    test_zero_write();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
